prog_loader: RTL and testbench
==============================

Name: prog_loader

Overview:
- Writer side of the program memory that the fetch stage reads.
- Receives a byte stream over a valid/ready handshake, assembles 32-bit little-endian words, and writes them to word-addressed program memory starting at address 0.
- Holds the CPU (CPU_HOLD) while loading.
- Verifies a trailing XOR checksum and reports DONE or ERR.

Parameters:
- MEM_DEPTH, 256, number of 32-bit words in program memory; word counts above this are rejected.
- ADDR_W, 32, width of MEM_ADDR, matching the PC width.

Ports:
- CLOCK  input  1  system clock; all logic on the rising edge.
- RESET_N  input  1  synchronous active-low reset.
- START  input  1  single-cycle pulse that begins a load; ignored unless state is IDLE, DONE or ERROR.
- BYTE_IN  input  8  stream byte.
- BYTE_VALID  input  1  BYTE_IN is valid.
- BYTE_READY  output  1  loader accepts a byte this cycle.
- MEM_WE  output  1  program memory write strobe, one cycle per word.
- MEM_ADDR  output  ADDR_W  word address (PC-style, increments by 1).
- MEM_DATA  output  32  word to write.
- CPU_HOLD  output  1  high while a load is in progress.
- DONE  output  1  load completed with matching checksum; sticky.
- ERR  output  1  load aborted (bad count or checksum mismatch); sticky.

Behaviour:
- Reset (RESET_N=0 at a rising edge):
  - State IDLE.
  - All outputs 0, including MEM_WE, CPU_HOLD, DONE, ERR and BYTE_READY.
  - Byte counter, word index, count register and checksum accumulator cleared.
- Reset mid-load: aborts immediately. No further MEM_WE. Words already written are not undone.
- Byte transfer: a byte transfers only on a cycle where BYTE_VALID=1 and BYTE_READY=1.
- BYTE_READY is 1 in states HDR, DATA and CSUM, and 0 otherwise. There is no back-pressure inside a load.
- Word assembly:
  - 2-bit byte counter; byte k of a word fills bits [8k+7:8k] (little-endian).
  - The counter wraps 3 to 0 when a word completes.
- States and transitions:
  - IDLE: START moves to HDR. On that same edge, DONE, ERR, checksum and word index clear and CPU_HOLD goes to 1.
  - DONE / ERROR: behave as IDLE for START, which restarts the load and clears both flags.
  - HDR: collects 4 bytes to form N (word count).
    - N > MEM_DEPTH: go to ERROR.
    - N == 0: go to CSUM.
    - Otherwise: go to DATA.
  - DATA:
    - Each completed word is registered. On the following cycle MEM_WE=1 for exactly one cycle, with MEM_ADDR = word index and MEM_DATA = the word.
    - The word index then increments, and the checksum accumulator XORs the word in.
    - After word N-1 completes, go to CSUM. The final MEM_WE pulse still occurs in the first CSUM cycle.
  - CSUM: collects 4 bytes and compares them against the accumulator (which includes the final data word).
    - Equal: go to DONE, DONE=1.
    - Not equal: go to ERROR, ERR=1.
    - In both cases CPU_HOLD drops to 0 on the same edge.
  - ERROR from HDR: ERR=1 and CPU_HOLD=0 on the transition edge. No memory writes occur.
- Latency:
  - First MEM_WE is one cycle after the 4th byte of the first data word is accepted.
  - DONE/ERR assert on the edge that accepts the last checksum byte.
- MEM_ADDR and MEM_DATA hold their last written values while MEM_WE=0.
- Address width rules:
  - The word index is ADDR_W bits and never wraps, because N ≤ MEM_DEPTH.
  - N is compared as a full 32-bit unsigned value.
- Simultaneous events:
  - RESET_N=0 wins over START and over any byte transfer.
  - START while in HDR, DATA or CSUM is ignored.
  - BYTE_VALID while in IDLE, DONE or ERROR is not accepted, since BYTE_READY=0.
- Exactly one pulse: DONE and ERR are never both 1.

Test Plan:
- Nominal load:
  - Stimulus: START, then bytes 02 00 00 00, 44 33 22 11, DD CC BB AA, 99 FF 99 BB.
  - Required: MEM_WE pulses at addr 0 with 0x11223344 and at addr 1 with 0xAABBCCDD; DONE=1, ERR=0, CPU_HOLD falls.
- Checksum mismatch:
  - Stimulus: same stream with final byte BC.
  - Required: both writes occur, then ERR=1, DONE=0.
- Oversize count:
  - Stimulus: header N=257 (01 01 00 00) with MEM_DEPTH=256.
  - Required: ERR=1 after the 4th header byte; zero MEM_WE pulses; BYTE_READY=0.
- Empty program and idle-start rules:
  - Stimulus: N=0, checksum 00 00 00 00.
  - Required: DONE=1 with no writes.
  - Stimulus: START pulsed mid-DATA.
  - Required: ignored; addresses continue sequentially.
- Reset mid-load:
  - Stimulus: RESET_N=0 after word 0 is written (N=2).
  - Required: next cycle all outputs 0, state IDLE; a subsequent START reloads from addr 0.
- Handshake gaps:
  - Stimulus: nominal stream with BYTE_VALID deasserted for random 0–5 cycles between bytes.
  - Required: identical writes and DONE=1; no byte is lost or duplicated.

Source files
------------

// File: rtl/prog_loader.sv
// Program-memory writer: takes a byte stream, assembles little-endian 32-bit words,
// writes them from address 0 upward while holding the CPU, and checks a trailing XOR sum.
module prog_loader #(
  parameter int MEM_DEPTH = 256,
  parameter int ADDR_W    = 32
) (
  input  logic              CLOCK,
  input  logic              RESET_N,
  input  logic              START,
  input  logic [7:0]        BYTE_IN,
  input  logic              BYTE_VALID,
  output logic              BYTE_READY,
  output logic              MEM_WE,
  output logic [ADDR_W-1:0] MEM_ADDR,
  output logic [31:0]       MEM_DATA,
  output logic              CPU_HOLD,
  output logic              DONE,
  output logic              ERR
);

  typedef enum logic [2:0] {
    S_IDLE, S_HDR, S_DATA, S_CSUM, S_DONE, S_ERROR
  } state_t;

  state_t            state_q, state_d;
  logic [1:0]        byte_cnt_q, byte_cnt_d;
  logic [31:0]       asm_q, asm_d;
  logic [31:0]       count_q, count_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [31:0]       csum_q, csum_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       data_q, data_d;
  logic              hold_q, hold_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  logic        xfer;
  logic        word_done;
  logic [31:0] asm_next;

  assign BYTE_READY = (state_q == S_HDR) || (state_q == S_DATA) || (state_q == S_CSUM);
  assign xfer       = BYTE_VALID && BYTE_READY;
  // Shifting in from the top leaves byte 0 in bits [7:0] after four transfers.
  assign asm_next   = {BYTE_IN, asm_q[31:8]};
  assign word_done  = xfer && (byte_cnt_q == 2'd3);

  always_comb begin
    state_d    = state_q;
    byte_cnt_d = byte_cnt_q;
    asm_d      = asm_q;
    count_d    = count_q;
    idx_d      = idx_q;
    csum_d     = csum_q;
    we_d       = 1'b0;
    addr_d     = addr_q;
    data_d     = data_q;
    hold_d     = hold_q;
    done_d     = done_q;
    err_d      = err_q;

    if (xfer) begin
      asm_d      = asm_next;
      byte_cnt_d = byte_cnt_q + 2'd1;
    end

    unique case (state_q)
      S_IDLE, S_DONE, S_ERROR: begin
        if (START) begin
          state_d    = S_HDR;
          done_d     = 1'b0;
          err_d      = 1'b0;
          csum_d     = '0;
          idx_d      = '0;
          byte_cnt_d = '0;
          hold_d     = 1'b1;
        end
      end
      S_HDR: begin
        if (word_done) begin
          count_d = asm_next;
          if (asm_next > 32'(MEM_DEPTH)) begin
            state_d = S_ERROR;
            err_d   = 1'b1;
            hold_d  = 1'b0;
          end else if (asm_next == 32'd0) begin
            state_d = S_CSUM;
          end else begin
            state_d = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (word_done) begin
          we_d   = 1'b1;
          addr_d = idx_q;
          data_d = asm_next;
          idx_d  = idx_q + 1'b1;
          csum_d = csum_q ^ asm_next;
          if (32'(idx_q) == count_q - 32'd1) begin
            state_d = S_CSUM;
          end
        end
      end
      S_CSUM: begin
        if (word_done) begin
          hold_d = 1'b0;
          if (asm_next == csum_q) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else begin
            state_d = S_ERROR;
            err_d   = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLOCK) begin
    if (!RESET_N) begin
      state_q    <= S_IDLE;
      byte_cnt_q <= '0;
      asm_q      <= '0;
      count_q    <= '0;
      idx_q      <= '0;
      csum_q     <= '0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      data_q     <= '0;
      hold_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      byte_cnt_q <= byte_cnt_d;
      asm_q      <= asm_d;
      count_q    <= count_d;
      idx_q      <= idx_d;
      csum_q     <= csum_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      hold_q     <= hold_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign MEM_WE   = we_q;
  assign MEM_ADDR = addr_q;
  assign MEM_DATA = data_q;
  assign CPU_HOLD = hold_q;
  assign DONE     = done_q;
  assign ERR      = err_q;

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: expected writes go into a queue as words are sent
// and are popped by a monitor whenever MEM_WE pulses.
module tb_prog_loader;
  localparam int DEPTH = 256;

  logic        clk = 1'b0;
  logic        rst_n, start, byte_valid;
  logic [7:0]  byte_in;
  logic        byte_ready, mem_we, cpu_hold, done, err;
  logic [31:0] mem_addr, mem_data;

  int pass_cnt  = 0;
  int total_cnt = 0;
  logic [63:0] exp_q[$];
  logic [31:0] words[0:DEPTH-1];

  always #5 clk = ~clk;

  prog_loader #(.MEM_DEPTH(DEPTH), .ADDR_W(32)) dut (
    .CLOCK(clk), .RESET_N(rst_n), .START(start), .BYTE_IN(byte_in),
    .BYTE_VALID(byte_valid), .BYTE_READY(byte_ready), .MEM_WE(mem_we),
    .MEM_ADDR(mem_addr), .MEM_DATA(mem_data), .CPU_HOLD(cpu_hold),
    .DONE(done), .ERR(err)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Every write strobe must match the oldest outstanding expected write.
  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      check("we_expected", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) check("write_addr_data", {mem_addr, mem_data}, exp_q.pop_front());
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic send_byte(input logic [7:0] b, input int gap);
    int n;
    repeat (gap) begin
      @(negedge clk);
      byte_valid = 1'b0;
    end
    @(negedge clk);
    byte_valid = 1'b1;
    byte_in    = b;
    n = 0;
    while (!byte_ready && n < 8) begin
      @(negedge clk);
      n++;
    end
    check("byte_ready", 64'(byte_ready), 64'd1);
    @(posedge clk);
  endtask

  task automatic send_word(input logic [31:0] w, input int maxgap);
    for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8], int'($urandom_range(0, maxgap)));
  endtask

  task automatic pulse_start();
    @(negedge clk);
    byte_valid = 1'b0;
    start      = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("start_hold", 64'(cpu_hold), 64'd1);
    check("start_flags", {62'd0, done, err}, 64'd0);
    check("start_ready", 64'(byte_ready), 64'd1);
  endtask

  task automatic load(input logic [31:0] n, input int nw, input logic [31:0] flip, input int maxgap);
    logic [31:0] cs;
    cs = 32'd0;
    pulse_start();
    send_word(n, maxgap);
    for (int i = 0; i < nw; i++) begin
      exp_q.push_back({32'(i), words[i]});
      cs ^= words[i];
      send_word(words[i], maxgap);
    end
    if (n <= 32'(DEPTH)) send_word(cs ^ flip, maxgap);
  endtask

  task automatic end_checks(input string tag, input logic exp_done, input logic exp_err);
    #1;
    check({tag, "_done"}, 64'(done), 64'(exp_done));
    check({tag, "_err"}, 64'(err), 64'(exp_err));
    check({tag, "_hold"}, 64'(cpu_hold), 64'd0);
    check({tag, "_ready"}, 64'(byte_ready), 64'd0);
    check({tag, "_drained"}, 64'(exp_q.size()), 64'd0);
    @(negedge clk);
    byte_valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; byte_valid = 1'b0; byte_in = 8'h00;
    words[0] = 32'h1122_3344;
    words[1] = 32'hAABB_CCDD;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", {57'd0, byte_ready, mem_we, cpu_hold, done, err, 2'd0}, 64'd0);
    check("reset_addr_data", {mem_addr, mem_data}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Nominal two-word load: checksum 0xBB99FF99.
    load(32'd2, 2, 32'd0, 0);
    end_checks("nominal", 1'b1, 1'b0);
    check("nominal_hold_addr_data", {mem_addr, mem_data}, {32'd1, 32'hAABB_CCDD});
    $display("nominal: done=%0b err=%0b", done, err);

    // Final checksum byte BC instead of BB.
    load(32'd2, 2, 32'h0700_0000, 0);
    end_checks("csum_bad", 1'b0, 1'b1);
    $display("csum_bad: done=%0b err=%0b", done, err);

    // Header just over depth, and one whose low bits alone would look empty.
    load(32'd257, 0, 32'd0, 0);
    end_checks("oversize_257", 1'b0, 1'b1);
    $display("oversize_257: err=%0b", err);
    load(32'h0001_0000, 0, 32'd0, 0);
    end_checks("oversize_64k", 1'b0, 1'b1);
    $display("oversize_64k: err=%0b", err);

    // Empty program.
    load(32'd0, 0, 32'd0, 0);
    end_checks("empty", 1'b1, 1'b0);
    $display("empty: done=%0b", done);

    // START pulsed in the middle of DATA must be ignored.
    words[2] = 32'hDEAD_BEEF;
    pulse_start();
    send_word(32'd3, 0);
    exp_q.push_back({32'd0, words[0]});
    send_word(words[0], 0);
    send_byte(words[1][7:0], 0);
    @(negedge clk);
    byte_valid = 1'b0;
    start      = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("mid_start_hold", 64'(cpu_hold), 64'd1);
    exp_q.push_back({32'd1, words[1]});
    for (int k = 1; k < 4; k++) send_byte(words[1][8*k +: 8], 0);
    exp_q.push_back({32'd2, words[2]});
    send_word(words[2], 0);
    send_word(words[0] ^ words[1] ^ words[2], 0);
    end_checks("mid_start", 1'b1, 1'b0);
    $display("mid_start: done=%0b addr=%0d", done, mem_addr);

    // Reset after word 0 of a two-word load has been written.
    pulse_start();
    send_word(32'd2, 0);
    exp_q.push_back({32'd0, words[0]});
    send_word(words[0], 0);
    @(negedge clk);
    byte_valid = 1'b0;
    rst_n      = 1'b0;
    @(posedge clk);
    #1;
    check("midreset_outputs", {57'd0, byte_ready, mem_we, cpu_hold, done, err, 2'd0}, 64'd0);
    check("midreset_addr_data", {mem_addr, mem_data}, 64'd0);
    check("midreset_drained", 64'(exp_q.size()), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    // Bytes offered while idle are refused.
    byte_valid = 1'b1;
    byte_in    = 8'hFF;
    repeat (3) @(negedge clk);
    check("idle_not_ready", 64'(byte_ready), 64'd0);
    $display("mid_reset: outputs cleared");

    // Reload from address 0 with random handshake gaps.
    load(32'd2, 2, 32'd0, 5);
    end_checks("gaps", 1'b1, 1'b0);
    $display("gaps: done=%0b", done);

    // Full-depth load.
    for (int i = 0; i < DEPTH; i++) words[i] = $urandom;
    load(32'(DEPTH), DEPTH, 32'd0, 0);
    end_checks("full_depth", 1'b1, 1'b0);
    check("full_depth_last_addr", 64'(mem_addr), 64'(DEPTH - 1));
    $display("full_depth: done=%0b last_addr=%0d", done, mem_addr);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
